bch_encode_serial: RTL and testbench

Systematic BCH encoder, the transmit-side counterpart of the syndrome calculators. It accepts message bits BITS per enabled cycle, passes them through unchanged and accumulates parity in a generator-polynomial LFSR. It then appends the ECC_BITS parity bits, BITS per enabled cycle, MSB first. It sits between the data source and the channel, and its output stream is what the syndrome calculators consume.

---
 rtl/bch_encode_serial.sv | 198 +++++++++++++++++++
 tb/tb_bch_encode_serial.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_encode_serial.sv
// -----------------------------------------------------------------------------
// bch_encode_serial
//
// Systematic BCH encoder. Message bits arrive BITS per enabled beat. They are
// forwarded unchanged and folded into a generator-polynomial LFSR. The
// ECC_BITS parity bits then follow, BITS per enabled beat, MSB first.
//
// Parameters
//   DATA_BITS  message bits per codeword (k)
//   ECC_BITS   parity bits per codeword (n-k), also the LFSR width
//   GENERATOR  g(x), ECC_BITS+1 bits, bit i = coefficient of x^i, top bit 1
//   BITS       bits per beat; must divide DATA_BITS and ECC_BITS
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     current beat is the first message beat
//   ce        clock enable, one beat per cycle with ce=1
//   data_in   message bits, MSB = earliest bit
//   ready     a message beat can be accepted (decoded from state only)
//   data_out  registered codeword bits
//   valid     data_out holds a codeword beat
//   first     data_out holds the first beat of a codeword
//   last      data_out holds the final parity beat
//
// Build option
//   BCH_ENC_RESTART_EN  when defined, start during parity output abandons the
//                       parity and begins a new codeword; otherwise start is
//                       ignored until the parity has been sent.
// -----------------------------------------------------------------------------
module bch_encode_serial #(
  parameter int                  DATA_BITS = 7,
  parameter int                  ECC_BITS  = 8,
  parameter logic [ECC_BITS:0]   GENERATOR = 9'h1D1,
  parameter int                  BITS      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ce,
  input  logic [BITS-1:0] data_in,
  output logic            ready,
  output logic [BITS-1:0] data_out,
  output logic            valid,
  output logic            first,
  output logic            last
);

  localparam int DATA_BEATS = DATA_BITS / BITS;
  localparam int ECC_BEATS  = ECC_BITS / BITS;
  localparam int MAX_BEATS  = (DATA_BEATS > ECC_BEATS) ? DATA_BEATS : ECC_BEATS;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS);
  localparam logic [CNT_W-1:0] ECC_LAST  = CNT_W'(ECC_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Reject configurations the datapath cannot represent.
  generate
    if ((DATA_BITS % BITS) != 0 || (ECC_BITS % BITS) != 0 ||
        GENERATOR[ECC_BITS] != 1'b1) begin : g_bad_cfg
      $error("bch_encode_serial: BITS must divide DATA_BITS and ECC_BITS, and GENERATOR must be monic");
    end
  endgenerate

  // BITS serial LFSR steps unrolled into one beat, MSB of the beat first.
  function automatic logic [ECC_BITS-1:0] lfsr_step(
    input logic [ECC_BITS-1:0] seed,
    input logic [BITS-1:0]     bits
  );
    logic [ECC_BITS-1:0] s;
    logic                fb;
    s = seed;
    for (int i = BITS - 1; i >= 0; i--) begin
      fb = s[ECC_BITS-1] ^ bits[i];
      s  = (s << 1) ^ (fb ? GENERATOR[ECC_BITS-1:0] : '0);
    end
    return s;
  endfunction

  logic [1:0]          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ECC_BITS-1:0] lfsr_reg, lfsr_next;
  logic [BITS-1:0]     dout_reg, dout_next;
  logic                valid_reg, valid_next;
  logic                first_reg, first_next;
  logic                last_reg, last_next;
  logic                start_ok;
  logic [CNT_W-1:0]    cnt_inc;

`ifdef BCH_ENC_RESTART_EN
  // start is honoured in every state, including mid-parity.
  assign start_ok = start;
  assign ready    = 1'b1;
`else
  assign start_ok = start && (state_reg != ST_PARITY);
  assign ready    = (state_reg != ST_PARITY);
`endif

  assign cnt_inc = cnt_reg + CNT_ONE;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lfsr_next  = lfsr_reg;
    dout_next  = dout_reg;
    valid_next = valid_reg;
    first_next = first_reg;
    last_next  = last_reg;

    if (ce) begin
      if (start_ok) begin
        // New codeword: seed from zero, never from leftover LFSR contents.
        lfsr_next  = lfsr_step('0, data_in);
        dout_next  = data_in;
        valid_next = 1'b1;
        first_next = 1'b1;
        last_next  = 1'b0;
        if (DATA_BEATS == 1) begin
          state_next = ST_PARITY;
          cnt_next   = '0;
        end else begin
          state_next = ST_DATA;
          cnt_next   = CNT_ONE;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            valid_next = 1'b0;
            first_next = 1'b0;
            last_next  = 1'b0;
          end
          ST_DATA: begin
            lfsr_next  = lfsr_step(lfsr_reg, data_in);
            dout_next  = data_in;
            valid_next = 1'b1;
            first_next = 1'b0;
            last_next  = 1'b0;
            if (cnt_inc == DATA_LAST) begin
              state_next = ST_PARITY;
              cnt_next   = '0;
            end else begin
              cnt_next   = cnt_inc;
            end
          end
          ST_PARITY: begin
            dout_next  = lfsr_reg[ECC_BITS-1 -: BITS];
            lfsr_next  = lfsr_reg << BITS;
            valid_next = 1'b1;
            first_next = 1'b0;
            if (cnt_inc == ECC_LAST) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              last_next  = 1'b1;
            end else begin
              cnt_next   = cnt_inc;
              last_next  = 1'b0;
            end
          end
          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      lfsr_reg  <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lfsr_reg  <= lfsr_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      first_reg <= first_next;
      last_reg  <= last_next;
    end
  end

  assign data_out = dout_reg;
  assign valid    = valid_reg;
  assign first    = first_reg;
  assign last     = last_reg;

endmodule

// File: tb/tb_bch_encode_serial.sv
module tb_bch_encode_serial;

  logic       clk;
  logic       reset;
  logic       start;
  logic       ce;
  logic [0:0] data_in;
  logic       ready;
  logic [0:0] data_out;
  logic       valid;
  logic       first;
  logic       last;

  int checks   = 0;
  int failures = 0;

`ifdef BCH_ENC_RESTART_EN
  localparam int RDY_LOW_EXP = 0;
`else
  localparam int RDY_LOW_EXP = 8;
`endif

  bch_encode_serial #(
    .DATA_BITS (7),
    .ECC_BITS  (8),
    .GENERATOR (9'h1D1),
    .BITS      (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ce       (ce),
    .data_in  (data_in),
    .ready    (ready),
    .data_out (data_out),
    .valid    (valid),
    .first    (first),
    .last     (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of a received 15-bit word modulo g(x) = 0x1D1 by long division.
  function automatic logic [7:0] poly_mod(input logic [14:0] w);
    logic [14:0] r;
    logic [14:0] g;
    r = w;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) begin
        g = 15'h1D1 << (i - 8);
        r = r ^ g;
      end
    end
    return r[7:0];
  endfunction

  // One beat: apply inputs, take the edge, sample 1 time unit later.
  task automatic drive(input logic s, input logic d, input logic e);
    start      = s;
    data_in[0] = d;
    ce         = e;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cw(input logic [6:0] msg, output logic [14:0] cw,
                        output int n_first, output int n_last,
                        output int first_pos, output int last_pos,
                        output int rdy_low, output int bad_valid);
    logic d;
    cw = '0; n_first = 0; n_last = 0; first_pos = 0; last_pos = 0;
    rdy_low = 0; bad_valid = 0;
    for (int i = 0; i < 15; i++) begin
      d = 1'b0;
      if (i < 7) d = msg[6 - i];
      drive(i == 0, d, 1'b1);
      cw = {cw[13:0], data_out[0]};
      if (first) begin n_first++; first_pos = i + 1; end
      if (last)  begin n_last++;  last_pos  = i + 1; end
      if (!ready) rdy_low++;
      if (!valid) bad_valid++;
    end
    start = 1'b0;
    ce    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; ce = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_out, valid, first, last} !== 4'b0000 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got dout=%b valid=%b first=%b last=%b ready=%b, want 0 0 0 0 1",
               data_out, valid, first, last, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic check_cw(input string name, input logic [14:0] got, input logic [14:0] want,
                          input int nf, input int nl, input int fp, input int lp,
                          input int rl, input int bv);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s_stream: got %b want %b", name, got, want);
    end
    checks++;
    if (poly_mod(got) !== 8'h00) begin
      failures++;
      $display("FAIL %s_remainder: got %h want 00", name, poly_mod(got));
    end
    checks++;
    if (nf !== 1 || nl !== 1 || fp !== 1 || lp !== 15) begin
      failures++;
      $display("FAIL %s_markers: first n=%0d pos=%0d last n=%0d pos=%0d, want 1 1 1 15",
               name, nf, fp, nl, lp);
    end
    checks++;
    if (rl !== RDY_LOW_EXP || bv !== 0) begin
      failures++;
      $display("FAIL %s_ready_valid: ready-low beats=%0d want %0d, invalid beats=%0d want 0",
               name, rl, RDY_LOW_EXP, bv);
    end
    $display("codeword %s: %b", name, got);
  endtask

  task automatic test_unit_message;
    logic [14:0] cw; int nf, nl, fp, lp, rl, bv;
    run_cw(7'b0000001, cw, nf, nl, fp, lp, rl, bv);
    check_cw("unit", cw, {7'b0000001, 8'hD1}, nf, nl, fp, lp, rl, bv);
  endtask

  task automatic test_x6_message;
    logic [14:0] cw; int nf, nl, fp, lp, rl, bv;
    run_cw(7'b1000000, cw, nf, nl, fp, lp, rl, bv);
    check_cw("x6", cw, {7'b1000000, 8'hE8}, nf, nl, fp, lp, rl, bv);
  endtask

  task automatic test_back_to_back;
    logic [14:0] cw0, cw1; int nf, nl, fp, lp, rl, bv;
    ce = 1'b1;
    run_cw(7'b0000000, cw0, nf, nl, fp, lp, rl, bv);
    check_cw("zero", cw0, 15'h0000, nf, nl, fp, lp, rl, bv);
    run_cw(7'b1011001, cw1, nf, nl, fp, lp, rl, bv);
    check_cw("b2b", cw1, {7'b1011001, 8'h1E}, nf, nl, fp, lp, rl, bv);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (valid !== 1'b0 || last !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_b2b: valid=%b last=%b, want 0 0", valid, last);
    end
  endtask

  task automatic test_ce_gaps;
    logic [14:0] cw;
    logic [6:0]  msg;
    logic [3:0]  snap;
    logic        d;
    int          hold_err, nf, nl;
    msg = 7'b1011001;
    cw = '0; hold_err = 0; nf = 0; nl = 0;
    for (int i = 0; i < 15; i++) begin
      snap = {data_out[0], valid, first, last};
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        if ({data_out[0], valid, first, last} !== snap) hold_err++;
      end
      d = 1'b0;
      if (i < 7) d = msg[6 - i];
      drive(i == 0, d, 1'b1);
      cw = {cw[13:0], data_out[0]};
      if (first) nf++;
      if (last)  nl++;
    end
    ce = 1'b0; start = 1'b0;
    checks++;
    if (cw !== {7'b1011001, 8'h1E}) begin
      failures++;
      $display("FAIL gaps_stream: got %b want %b", cw, {7'b1011001, 8'h1E});
    end
    checks++;
    if (hold_err !== 0) begin
      failures++;
      $display("FAIL gaps_hold: %0d gap beats changed outputs, want 0", hold_err);
    end
    checks++;
    if (nf !== 1 || nl !== 1) begin
      failures++;
      $display("FAIL gaps_markers: first=%0d last=%0d, want 1 1", nf, nl);
    end
    $display("codeword gaps: %b", cw);
  endtask

  task automatic test_async_reset;
    logic [14:0] cw; int nf, nl, fp, lp, rl, bv;
    logic [6:0] msg;
    msg = 7'b0000001;
    for (int i = 0; i < 7; i++) drive(i == 0, msg[6 - i], 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
    ce = 1'b0;
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %b want 1", valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({data_out, valid, first, last} !== 4'b0000 || ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got dout=%b valid=%b first=%b last=%b ready=%b, want 0 0 0 0 1",
               data_out, valid, first, last, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    run_cw(7'b0000001, cw, nf, nl, fp, lp, rl, bv);
    check_cw("post_reset", cw, {7'b0000001, 8'hD1}, nf, nl, fp, lp, rl, bv);
  endtask

  task automatic test_restart;
    logic [6:0] msg;
    logic [7:0] par;
    int         nl;
    msg = 7'b1000000;
    par = '0; nl = 0;
    for (int i = 0; i < 7; i++) drive(i == 0, msg[6 - i], 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      par = {par[6:0], data_out[0]};
    end
`ifdef BCH_ENC_RESTART_EN
    begin
      logic [14:0] cw;
      logic [6:0]  m2;
      m2 = 7'b0000001;
      cw = '0;
      for (int i = 0; i < 15; i++) begin
        logic d;
        d = 1'b0;
        if (i < 7) d = m2[6 - i];
        drive(i == 0, d, 1'b1);
        cw = {cw[13:0], data_out[0]};
        if (i == 0) begin
          checks++;
          if (first !== 1'b1 || last !== 1'b0) begin
            failures++;
            $display("FAIL restart_first: first=%b last=%b, want 1 0", first, last);
          end
        end
        if (last && i != 14) nl++;
      end
      ce = 1'b0; start = 1'b0;
      checks++;
      if (nl !== 0 || last !== 1'b1) begin
        failures++;
        $display("FAIL restart_last: early last=%0d want 0, final last=%b want 1", nl, last);
      end
      checks++;
      if (cw !== {7'b0000001, 8'hD1}) begin
        failures++;
        $display("FAIL restart_stream: got %b want %b", cw, {7'b0000001, 8'hD1});
      end
      $display("codeword restart: %b", cw);
    end
`else
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL parity_ready: got %b want 0", ready);
    end
    for (int i = 3; i < 8; i++) begin
      drive(i == 3, 1'b1, 1'b1);
      par = {par[6:0], data_out[0]};
      if (i == 3) begin
        checks++;
        if (first !== 1'b0) begin
          failures++;
          $display("FAIL ignored_start_first: got %b want 0", first);
        end
      end
      if (last && i != 7) nl++;
    end
    ce = 1'b0; start = 1'b0;
    checks++;
    if (par !== 8'hE8) begin
      failures++;
      $display("FAIL ignored_start_parity: got %h want e8", par);
    end
    checks++;
    if (nl !== 0 || last !== 1'b1) begin
      failures++;
      $display("FAIL ignored_start_last: early last=%0d want 0, final last=%b want 1", nl, last);
    end
    $display("parity ignored-start: %h", par);
`endif
  endtask

  initial begin
    test_reset;
    test_unit_message;
    test_x6_message;
    test_back_to_back;
    test_ce_gaps;
    test_async_reset;
    test_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
